// File: rtl/sec_of_day_counter.sv
// sec_of_day_counter: 1 Hz seconds-of-day timebase, cur_sec in 0..DAY_SEC-1.
// Optional macro HOUR_STROBE_EN adds the hour_strobe output.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   en                1 = time runs, 0 = time and prescaler hold
//   set_valid/ready   absolute load handshake, set_sec is the value
//   set_err           1-cycle pulse when a loaded value was out of range
//   inc_hour/inc_min  1-cycle nudges of +3600 s / +60 s
//   cur_sec           registered seconds-of-day
//   sec_tick          1-cycle pulse in the cycle a 1 s tick lands
//   hour_strobe       (HOUR_STROBE_EN) tick landed on a whole hour
module sec_of_day_counter #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int DAY_SEC = 86400
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        set_valid,
    input  logic [16:0] set_sec,
    output logic        set_ready,
    output logic        set_err,
    input  logic        inc_hour,
    input  logic        inc_min,
    output logic [16:0] cur_sec,
`ifdef HOUR_STROBE_EN
    output logic        hour_strobe,
`endif
    output logic        sec_tick
);

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        LOAD = 2'd2
    } state_t;

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PS_TC = PW'(CLK_HZ - 1);
    localparam logic [17:0] DAY  = 18'(DAY_SEC);
    localparam logic [17:0] LAST = 18'(DAY_SEC - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] ps_q, ps_d;
    logic          rdy_q;
    logic [16:0]   cur_d;
    logic          accept;
    logic          tick;
    logic          bad;
    logic [17:0]   cur18;
    logic [17:0]   ticked;
    logic [17:0]   add;
    logic [17:0]   sum;
    logic [17:0]   wrapped;

    assign accept = set_valid & rdy_q;
    assign tick   = (state_q == RUN) & (ps_q == PS_TC);
    assign bad    = {1'b0, set_sec} >= DAY;
    assign cur18  = {1'b0, cur_sec};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HOLD:    if (en) state_d = RUN;
            RUN:     if (!en) state_d = HOLD;
            LOAD:    state_d = en ? RUN : HOLD;
            default: state_d = HOLD;
        endcase
        if (accept) state_d = LOAD;
    end

    // A tick colliding with a nudge is applied first, then the nudge.
    always_comb begin
        ticked = cur18;
        if (tick) ticked = (cur18 == LAST) ? 18'd0 : cur18 + 18'd1;
        add = 18'd0;
        if (state_q != LOAD) begin
            if (inc_hour)     add = 18'd3600;
            else if (inc_min) add = 18'd60;
        end
        sum = ticked + add;
        wrapped = (sum >= DAY) ? sum - DAY : sum;
    end

    always_comb begin
        cur_d = 17'(wrapped);
        ps_d  = ps_q;
        if (accept) begin
            cur_d = bad ? cur_sec : set_sec;
            ps_d  = '0;
        end else if (state_q == RUN) begin
            ps_d = tick ? '0 : ps_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= HOLD;
            ps_q     <= '0;
            rdy_q    <= 1'b0;
            cur_sec  <= '0;
            set_err  <= 1'b0;
            sec_tick <= 1'b0;
        end else begin
            state_q  <= state_d;
            ps_q     <= ps_d;
            rdy_q    <= ~accept;
            cur_sec  <= cur_d;
            set_err  <= accept & bad;
            sec_tick <= tick & ~accept;
        end
    end

    assign set_ready = rdy_q;

`ifdef HOUR_STROBE_EN
    // Judged on the ticked value so a nudge never produces a strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hour_strobe <= 1'b0;
        end else begin
            hour_strobe <= tick & ~accept &
                           ((ticked % 18'd3600) == 18'd0);
        end
    end
`endif

endmodule
